vga_rx_sync: RTL and testbench
==============================

# vga_rx_sync

Pixel-clock-domain VGA timing receiver: the capture-side counterpart of the VGA timing generator. It samples an incoming hs/vs/rgb stream running on the same pixel clock and recovers the horizontal and vertical position of every sample. It validates line and frame totals against the 640x480@60 timing and declares lock, then emits per-pixel write strobes with coordinates and data. Sits between a loopback or external source and the frame-buffer writer.

## Interface
- H_SYNC, 96, hs pulse width in clocks (hs active-high)
- H_LEFT, 144, first active column (sync + back porch)
- H_VIDEO, 784, first column after active video
- H_TOTAL, 800, clocks per line
- V_TOP, 35, first active line
- V_VIDEO, 515, first line after active video
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

- clk  input  1  pixel clock, 25.175 MHz
- rst  input  1  synchronous, active-high reset
- hs  input  1  horizontal sync, active-high
- vs  input  1  vertical sync, active-high
- rgb  input  12  pixel data
- locked  output  1  timing verified, pixel output valid
- frame_start  output  1  one-cycle pulse at each detected vs rising edge
- pix_we  output  1  pixel write strobe
- pix_x  output  10  column 0..639; 10'h3FF when pix_we=0
- pix_y  output  10  row 0..479; 10'h3FF when pix_we=0
- pix_data  output  12  captured rgb; 12'h000 when pix_we=0
- h_meas  output  11  last measured line length
- v_meas  output  11  last measured frame length in lines
- err_cnt  output  16  saturating count of timing errors

## Operation
- Input stage: hs, vs, rgb registered once (hs_q, vs_q, rgb_q); hs_d delays hs_q. Line start = hs_q & ~hs_d.
- hcnt (11 bit): position of sample in hs_q. Line start -> 0; else +1, saturating at 2047.
- At line start: h_meas <= previous hcnt+1; line_ok = (h_meas == H_TOTAL). vs_q sampled here; vs_q=1 with previous-line vs=0 -> frame start, vcnt <= 0, frame_start pulses. Else vcnt+1 (11 bit, saturating).
- At frame start: v_meas <= previous vcnt+1; frame_ok = (v_meas == V_TOTAL) and every line in that frame had line_ok.
- Timeouts: hcnt reaching 2*H_TOTAL, or vcnt reaching 2*V_TOTAL, = sync loss.
- FSM:
  - SEARCH: counts free-run; on first frame start -> TRACK, good-frame count = 0.
  - TRACK: each frame start with frame_ok increments count; count reaching LOCK_FRAMES -> LOCKED; bad frame resets count to 0 (stay TRACK); sync loss -> SEARCH.
  - LOCKED: any bad line length, bad frame length or sync loss -> SEARCH immediately (same cycle the error is detected).
- Each bad line, bad frame, or sync loss outside SEARCH increments err_cnt once (saturate at 16'hFFFF).
- Pixel output only in LOCKED: pix_we=1 when H_LEFT<=hcnt<H_VIDEO and V_TOP<=vcnt<V_VIDEO; pix_x=hcnt-H_LEFT, pix_y=vcnt-V_TOP, pix_data=rgb_q.
- Lock entered only at a frame start, so the first written frame is complete; lock loss mid-frame stops pix_we from the next cycle.

## Timing
- rst: SEARCH, hcnt=vcnt=0, locked=0, frame_start=0, pix_we=0, pix_x=pix_y=10'h3FF, pix_data=0, h_meas=v_meas=0, err_cnt=0.
- Latency input -> output: 2 cycles (input reg + output reg). rgb at pin on cycle n appears on pix_data at n+2.
- locked asserts registered, in the same cycle as the frame_start pulse of the qualifying frame.
- frame_start and line-start actions coincide when hs and vs rise together; both are handled in that cycle.
- No backpressure: pix_we is fire-and-forget, max 1 pixel per clock.

## Configuration
- VGA_RX_STATS_EN defined: h_meas, v_meas, err_cnt are live as described.
- Undefined: those three ports are tied to 0 and their registers are removed; lock behaviour is unchanged.

## Test plan
- Nominal generator stream after rst -> locked=1 at the start of the 3rd frame after the first vs edge (LOCK_FRAMES=2); h_meas=800, v_meas=525, err_cnt=0.
- Locked frame -> exactly 307200 pix_we per frame; first is pix_x=0, pix_y=0 with rgb from input hcnt=144, vcnt=35, 2 cycles later; last is (639,479).
- One line shortened to 799 clocks while locked -> locked falls in the cycle after that line's end, pix_we stops, err_cnt=1, and lock is regained two good frames later.
- Hold hs low for 1700 clocks -> sync loss at hcnt=1600, state SEARCH, err_cnt increments once.
- Frame of 524 lines in TRACK -> good-frame count resets and lock is delayed one extra frame.
- Assert rst mid-frame while locked -> next cycle all outputs hold their reset values, and relock follows the nominal sequence.

Source files
------------

// File: rtl/vga_rx_sync_if.sv
// Capture-side VGA bus: incoming hs/vs/rgb stream plus the recovered
// pixel write port and timing statistics.
interface vga_rx_sync_if;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        locked;
    logic        frame_start;
    logic        pix_we;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_data;
    logic [10:0] h_meas;
    logic [10:0] v_meas;
    logic [15:0] err_cnt;

    modport master (
        output hs, vs, rgb,
        input  locked, frame_start, pix_we, pix_x, pix_y, pix_data,
               h_meas, v_meas, err_cnt
    );

    modport slave (
        input  hs, vs, rgb,
        output locked, frame_start, pix_we, pix_x, pix_y, pix_data,
               h_meas, v_meas, err_cnt
    );
endinterface

// File: rtl/vga_rx_sync.sv
// VGA timing receiver: recovers x/y of each sample, verifies line/frame totals,
// locks and emits pixel writes. VGA_RX_STATS_EN enables h_meas/v_meas/err_cnt.
module vga_rx_sync #(
    parameter int H_SYNC      = 96,
    parameter int H_LEFT      = 144,
    parameter int H_VIDEO     = 784,
    parameter int H_TOTAL     = 800,
    parameter int V_TOP       = 35,
    parameter int V_VIDEO     = 515,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input logic          clk,
    input logic          rst,
    vga_rx_sync_if.slave bus
);

    localparam logic [10:0] HL    = 11'(H_LEFT);
    localparam logic [10:0] HV    = 11'(H_VIDEO);
    localparam logic [10:0] HT    = 11'(H_TOTAL);
    localparam logic [10:0] VTP   = 11'(V_TOP);
    localparam logic [10:0] VV    = 11'(V_VIDEO);
    localparam logic [10:0] VT    = 11'(V_TOTAL);
    localparam logic [10:0] H_TO  = 11'(2 * H_TOTAL);
    localparam logic [10:0] V_TO  = 11'(2 * V_TOTAL);
    localparam logic [3:0]  LF    = 4'(LOCK_FRAMES);

    if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15 || H_SYNC >= H_LEFT ||
        H_VIDEO > H_TOTAL || V_VIDEO > V_TOTAL) begin : g_cfg_check
        $error("vga_rx_sync: inconsistent timing parameters");
    end

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    logic        hs_q, vs_q, hs_dly_q, vs_line_q, vs_line_d;
    logic [11:0] rgb_q;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, hinc, vinc;
    logic        frame_bad_q, frame_bad_d;
    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        locked_q, frame_start_q, pix_we_q, pix_we_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [11:0] pix_data_q, pix_data_d;
    logic        line_start, frame_det, line_bad, frame_bad, sync_loss, in_win;

    always_comb begin
        // hcnt_d/vcnt_d are the position of the sample currently in hs_q
        hinc        = sat_inc(hcnt_q);
        vinc        = sat_inc(vcnt_q);
        line_start  = hs_q & ~hs_dly_q;
        frame_det   = line_start & vs_q & ~vs_line_q;
        hcnt_d      = line_start ? 11'd0 : hinc;
        vcnt_d      = frame_det ? 11'd0 : (line_start ? vinc : vcnt_q);
        vs_line_d   = line_start ? vs_q : vs_line_q;
        line_bad    = line_start & (hinc != HT);
        frame_bad   = frame_det & (line_bad | frame_bad_q | (vinc != VT));
        frame_bad_d = frame_det ? 1'b0 : (frame_bad_q | line_bad);
        sync_loss   = (hcnt_d == H_TO) | (line_start & (vcnt_d == V_TO));

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (frame_det) begin
                    state_d = TRACK;
                    good_d  = 4'd0;
                end
            end
            TRACK: begin
                if (sync_loss) begin
                    state_d = SEARCH;
                end else if (frame_det) begin
                    if (frame_bad) begin
                        good_d = 4'd0;
                    end else if (good_q + 4'd1 == LF) begin
                        state_d = LOCKED;
                        good_d  = 4'd0;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (sync_loss | line_bad | frame_bad) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase

        // Next state gates the write so a detected loss suppresses it at once
        in_win     = (hcnt_d >= HL) && (hcnt_d < HV) && (vcnt_d >= VTP) && (vcnt_d < VV);
        pix_we_d   = in_win && (state_d == LOCKED);
        pix_x_d    = pix_we_d ? 10'(hcnt_d - HL) : 10'h3FF;
        pix_y_d    = pix_we_d ? 10'(vcnt_d - VTP) : 10'h3FF;
        pix_data_d = pix_we_d ? rgb_q : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            rgb_q         <= '0;
            hs_dly_q      <= 1'b0;
            vs_line_q     <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_bad_q   <= 1'b0;
            state_q       <= SEARCH;
            good_q        <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            pix_we_q      <= 1'b0;
            pix_x_q       <= 10'h3FF;
            pix_y_q       <= 10'h3FF;
            pix_data_q    <= '0;
        end else begin
            hs_q          <= bus.hs;
            vs_q          <= bus.vs;
            rgb_q         <= bus.rgb;
            hs_dly_q      <= hs_q;
            vs_line_q     <= vs_line_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_bad_q   <= frame_bad_d;
            state_q       <= state_d;
            good_q        <= good_d;
            locked_q      <= (state_d == LOCKED);
            frame_start_q <= frame_det;
            pix_we_q      <= pix_we_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.frame_start = frame_start_q;
    assign bus.pix_we      = pix_we_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_data    = pix_data_q;

`ifdef VGA_RX_STATS_EN
    logic [10:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_evt;

    always_comb begin
        // At most one error per cycle, even if line and frame fail together
        err_evt   = (state_q != SEARCH) & (line_bad | frame_bad | sync_loss);
        h_meas_d  = line_start ? hinc : h_meas_q;
        v_meas_d  = frame_det ? vinc : v_meas_q;
        err_cnt_d = (err_evt && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_meas_q  <= '0;
            v_meas_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            h_meas_q  <= h_meas_d;
            v_meas_q  <= v_meas_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.h_meas  = h_meas_q;
    assign bus.v_meas  = v_meas_q;
    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.h_meas  = '0;
    assign bus.v_meas  = '0;
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_rx_sync.sv
// Scoreboard bench for vga_rx_sync on a shrunken 16x8 raster (active 8x4).
module tb_vga_rx_sync;

    localparam int HS = 4, HL = 6, HV = 14, HT = 16;
    localparam int VTP = 2, VV = 6, VT = 8, LF = 2;
`ifdef VGA_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct { int x; int y; logic [11:0] d; } pix_t;
    typedef struct { bit lk; bit dc; int h; int v; int err; } fs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rx_sync_if bus();

    vga_rx_sync #(
        .H_SYNC(HS), .H_LEFT(HL), .H_VIDEO(HV), .H_TOTAL(HT),
        .V_TOP(VTP), .V_VIDEO(VV), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0;
    pix_t pix_q[$];
    fs_t  fs_q[$];
    pix_t pe;
    fs_t  fe;

    function automatic logic [11:0] rgbf(int l, int c);
        return 12'(l * 64 + c) ^ 12'hA5A;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(logic h, logic v, logic [11:0] r);
        bus.hs  = h;
        bus.vs  = v;
        bus.rgb = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(int l, int len, bit lk, int chk_col);
        for (int c = 0; c < len; c++) begin
            if (lk && c >= HL && c < HV && l >= VTP && l < VV) begin
                pix_q.push_back('{c - HL, l - VTP, rgbf(l, c)});
                n_push++;
            end
            step(c < HS, l < 2, rgbf(l, c));
            if (chk_col >= 0 && c == chk_col) chk("lock_before_err", 32'(bus.locked), 1);
            if (chk_col >= 0 && c == chk_col + 1) chk("lock_drop", 32'(bus.locked), 0);
        end
    endtask

    // cut_line gets cut_len clocks; lines after it are not expected to write
    task automatic frame(int nl, bit lk, int cut_line, int cut_len, int chk_line, int chk_col,
                         bit e_lk, bit e_dc, int e_h, int e_v, int e_err);
        fs_q.push_back('{e_lk, e_dc, e_h, e_v, e_err});
        for (int l = 0; l < nl; l++) begin
            drive_line(l, (l == cut_line) ? cut_len : HT,
                       lk && (cut_line < 0 || l <= cut_line),
                       (l == chk_line) ? chk_col : -1);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_locked"}, 32'(bus.locked), 0);
        chk({tag, "_frame_start"}, 32'(bus.frame_start), 0);
        chk({tag, "_pix_we"}, 32'(bus.pix_we), 0);
        chk({tag, "_pix_x"}, 32'(bus.pix_x), 32'h3FF);
        chk({tag, "_pix_y"}, 32'(bus.pix_y), 32'h3FF);
        chk({tag, "_pix_data"}, 32'(bus.pix_data), 0);
        chk({tag, "_h_meas"}, 32'(bus.h_meas), 0);
        chk({tag, "_v_meas"}, 32'(bus.v_meas), 0);
        chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
    endtask

    always @(negedge clk) begin
        if (bus.pix_we === 1'b1) begin
            if (pix_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pix: got (%0d,%0d) expected no write", bus.pix_x, bus.pix_y);
            end else begin
                pe = pix_q.pop_front();
                n_pop++;
                chk("pix_x", 32'(bus.pix_x), pe.x);
                chk("pix_y", 32'(bus.pix_y), pe.y);
                chk("pix_data", 32'(bus.pix_data), 32'(pe.d));
            end
        end else begin
            chk("idle_pix_x", 32'(bus.pix_x), 32'h3FF);
            chk("idle_pix_y", 32'(bus.pix_y), 32'h3FF);
            chk("idle_pix_data", 32'(bus.pix_data), 0);
        end
        if (bus.frame_start === 1'b1) begin
            if (fs_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_frame_start: got pulse expected none");
            end else begin
                fe = fs_q.pop_front();
                chk("fs_locked", 32'(bus.locked), 32'(fe.lk));
                chk("fs_err_cnt", 32'(bus.err_cnt), STATS ? fe.err : 0);
                if (!fe.dc) begin
                    chk("fs_h_meas", 32'(bus.h_meas), STATS ? fe.h : 0);
                    chk("fs_v_meas", 32'(bus.v_meas), STATS ? fe.v : 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hs = 1'b0; bus.vs = 1'b0; bus.rgb = '0;
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 12'h000);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // acquire: TRACK at E1, good frames at E2/E3 -> locked at E3
        frame(8, 0, -1, 0, -1, -1, 0, 1, 0, 0, 0);
        frame(8, 0, -1, 0, -1, -1, 0, 0, HT, VT, 0);
        frame(8, 1, -1, 0, -1, -1, 1, 0, HT, VT, 0);
        // line 3 is 15 clocks: lock drops after its end, relock two frames later
        frame(8, 1, 3, 15, 4, 0, 1, 0, HT, VT, 0);
        frame(8, 0, -1, 0, -1, -1, 0, 0, HT, VT, 1);
        frame(8, 0, -1, 0, -1, -1, 0, 0, HT, VT, 1);
        frame(8, 1, -1, 0, -1, -1, 1, 0, HT, VT, 1);
        // 7-line frame while locked -> bad frame at next vs edge
        frame(7, 1, -1, 0, -1, -1, 1, 0, HT, VT, 1);
        frame(8, 0, -1, 0, -1, -1, 0, 0, HT, 7, 2);
        // 7-line frame in TRACK delays lock by one frame
        frame(7, 0, -1, 0, -1, -1, 0, 0, HT, VT, 2);
        frame(8, 0, -1, 0, -1, -1, 0, 0, HT, 7, 3);
        frame(8, 0, -1, 0, -1, -1, 0, 0, HT, VT, 3);
        frame(8, 1, -1, 0, -1, -1, 1, 0, HT, VT, 3);
        // hs held low: line 3 runs 40 clocks, timeout at position 32
        frame(4, 1, 3, 40, 3, 32, 1, 0, HT, VT, 3);
        frame(8, 0, -1, 0, -1, -1, 0, 0, 40, 4, 4);
        frame(8, 0, -1, 0, -1, -1, 0, 0, HT, VT, 4);
        frame(4, 1, -1, 0, -1, -1, 1, 0, HT, VT, 4);

        rst = 1'b1;
        step(1'b0, 1'b0, 12'h000);
        chk_reset_outputs("midreset");
        step(1'b0, 1'b0, 12'h000);
        rst = 1'b0;

        frame(8, 0, -1, 0, -1, -1, 0, 1, 0, 0, 0);
        frame(8, 0, -1, 0, -1, -1, 0, 0, HT, VT, 0);
        frame(8, 1, -1, 0, -1, -1, 1, 0, HT, VT, 0);
        repeat (4) step(1'b0, 1'b0, 12'h000);

        chk("pix_queue_empty", 32'(pix_q.size()), 0);
        chk("fs_queue_empty", 32'(fs_q.size()), 0);
        chk("pix_total", 32'(n_pop), 32'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
